// File: rtl/link_tx_framer_pkg.sv
// Shared definitions for the link transmit framer: FSM state encodings,
// beat-kind codes and fixed widths. The WAIT_ACK state exists only when the
// build defines LINK_REPLAY_EN.
package link_tx_framer_pkg;

  localparam int DATA_W = 4;
  localparam int SEQ_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SOF      = 3'd2,
    S_DATA     = 3'd3,
    S_EOF      = 3'd4
`ifdef LINK_REPLAY_EN
    , S_WAIT_ACK = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    KIND_IDLE = 2'b00,
    KIND_SOF  = 2'b01,
    KIND_DATA = 2'b10,
    KIND_EOF  = 2'b11
  } kind_t;

endpackage

// File: rtl/link_tx_framer_frame_buffer.sv
// Frame buffer for link_tx_framer: DEPTH x 4 register file written in order
// during fill, read in order during payload transmission, with a running XOR
// seeded by the frame's sequence number.
module link_frame_buffer
  import link_tx_framer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] seed,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_clr,
  input  logic              rd_adv,
  output logic [AW-1:0]     wr_idx,
  output logic [AW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] checksum
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage, write pointer and running checksum; a clear restarts a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: this small buffer is reset explicitly because a reset must leave no stale payload behind; large RAMs normally are not.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_idx   <= '0;
      checksum <= '0;
    end else if (clear) begin
      wr_idx   <= '0;
      checksum <= seed;
    end else if (wr_en) begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
      mem[wr_idx] <= wr_data;
      wr_idx      <= wr_idx + 1'b1;
      checksum    <= checksum ^ wr_data;
    end
  end

  // Read pointer walks the payload; rewinding allows a replay of the same frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       rd_idx <= '0;
    else if (rd_clr) rd_idx <= '0;
    else if (rd_adv) rd_idx <= rd_idx + 1'b1;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/link_tx_framer.sv
// Link transmit framer: pops PKT_LEN nibbles from the main FIFO and sends
// them as SOF+seq, payload beats, EOF+checksum on a ready/valid link.
// Optional feature: define LINK_REPLAY_EN to wait for ACK/NAK after each
// frame and resend the identical frame on NAK.
module link_tx_framer
  import link_tx_framer_pkg::*;
#(
  parameter int PKT_LEN = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [3:0]  fifo_dato,
  output logic        fifo_pop,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [1:0]  tx_kind,
  output logic [3:0]  tx_dato,
  input  logic        ack_in,
  input  logic        nak_in,
  output logic        busy,
  output logic [3:0]  seq_num,
  output logic [7:0]  frames_sent
);

  localparam int AW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int CW = $clog2(PKT_LEN + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(PKT_LEN - 1);
  localparam logic [CW-1:0] POP_MAX  = CW'(PKT_LEN);

  state_t            state, state_next;
  logic [CW-1:0]     pop_cnt;
  logic              capture;
  logic [SEQ_W-1:0]  seq;
  logic [7:0]        frames;
  logic              buf_clear, wr_en, rd_clr, rd_adv, frame_done;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic [DATA_W-1:0] rd_data, checksum;

`ifndef LINK_REPLAY_EN
  logic unused_ack_nak;
  assign unused_ack_nak = ack_in ^ nak_in;
`endif

  link_frame_buffer #(.DEPTH(PKT_LEN), .AW(AW)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .clear    (buf_clear),
    .seed     (seq),
    .wr_en    (wr_en),
    .wr_data  (fifo_dato),
    .rd_clr   (rd_clr),
    .rd_adv   (rd_adv),
    .wr_idx   (wr_idx),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .checksum (checksum)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Pop counter and one-cycle-delayed capture strobe (FIFO data lags the pop by a cycle).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pop_cnt <= '0;
      capture <= 1'b0;
    end else begin
      if (buf_clear)     pop_cnt <= '0;
      else if (fifo_pop) pop_cnt <= pop_cnt + 1'b1;
      capture <= fifo_pop;
    end
  end

  // Sequence number and completed-frame counter advance once per delivered frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seq    <= '0;
      frames <= '0;
    end else if (frame_done) begin
      seq    <= seq + 1'b1;
      frames <= frames + 1'b1;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_next = state;
    fifo_pop   = 1'b0;
    buf_clear  = 1'b0;
    wr_en      = 1'b0;
    rd_clr     = 1'b0;
    rd_adv     = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_next = S_FILL;
          buf_clear  = 1'b1;
        end
      end
      S_FILL: begin
        fifo_pop = !fifo_empty && (pop_cnt < POP_MAX);
        wr_en    = capture;
        if (capture && (wr_idx == LAST_IDX)) state_next = S_SOF;
      end
      S_SOF: begin
        rd_clr = 1'b1;
        if (tx_ready) state_next = S_DATA;
      end
      S_DATA: begin
        if (tx_ready) begin
          rd_adv = 1'b1;
          if (rd_idx == LAST_IDX) state_next = S_EOF;
        end
      end
      S_EOF: begin
        if (tx_ready) begin
`ifdef LINK_REPLAY_EN
          state_next = S_WAIT_ACK;
`else
          state_next = S_IDLE;
          frame_done = 1'b1;
`endif
        end
      end
`ifdef LINK_REPLAY_EN
      S_WAIT_ACK: begin
        if (nak_in) begin
          state_next = S_SOF;
        end else if (ack_in) begin
          state_next = S_IDLE;
          frame_done = 1'b1;
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Link beat decode from registered state and buffer contents only.
  always_comb begin
    tx_valid = 1'b0;
    tx_kind  = KIND_IDLE;
    tx_dato  = '0;
    case (state)
      S_SOF:  begin tx_valid = 1'b1; tx_kind = KIND_SOF;  tx_dato = seq;      end
      S_DATA: begin tx_valid = 1'b1; tx_kind = KIND_DATA; tx_dato = rd_data;  end
      S_EOF:  begin tx_valid = 1'b1; tx_kind = KIND_EOF;  tx_dato = checksum; end
      default: ;
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign seq_num     = seq;
  assign frames_sent = frames;

endmodule

// File: tb/tb_link_tx_framer.sv
// Self-checking bench for link_tx_framer: a FIFO model feeds nibbles, a
// scoreboard queue holds the expected link beats and a negedge monitor
// compares every accepted beat. Covers the LINK_REPLAY_EN build when defined.
module tb_link_tx_framer;
  import link_tx_framer_pkg::*;

  localparam int PKT_LEN = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic [3:0] fifo_dato;
  logic       fifo_pop;
  logic       tx_ready;
  logic       tx_valid;
  logic [1:0] tx_kind;
  logic [3:0] tx_dato;
  logic       ack_in;
  logic       nak_in;
  logic       busy;
  logic [3:0] seq_num;
  logic [7:0] frames_sent;

  always #5 clock = ~clock;

  link_tx_framer #(.PKT_LEN(PKT_LEN)) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_dato   (fifo_dato),
    .fifo_pop    (fifo_pop),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_kind     (tx_kind),
    .tx_dato     (tx_dato),
    .ack_in      (ack_in),
    .nak_in      (nak_in),
    .busy        (busy),
    .seq_num     (seq_num),
    .frames_sent (frames_sent)
  );

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
  } beat_t;

  int         compared   = 0;
  int         mismatched = 0;
  beat_t      exp_q[$];
  logic [3:0] fq[$];
  int         pops   = 0;
  logic       do_pop = 1'b0;
  logic [3:0] exp_seq;
  logic [7:0] exp_frames;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Monitor: count pops, compare each accepted beat against the scoreboard.
  always @(negedge clock) begin
    do_pop = fifo_pop;
    if (fifo_pop) begin
      pops++;
      check("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
    end
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", exp_q.size(), 1);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat_kind", {30'd0, tx_kind}, {30'd0, b.kind});
        check("beat_data", {28'd0, tx_dato}, {28'd0, b.data});
      end
    end
  end

  // FIFO model: read data appears the cycle after the pop.
  always @(posedge clock) begin
    #1;
    if (do_pop && fq.size() > 0) fifo_dato = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_nib(input logic [3:0] n);
    fq.push_back(n);
    fifo_empty = 1'b0;
  endtask

  task automatic load_fifo(input logic [4*PKT_LEN-1:0] p);
    for (int i = 0; i < PKT_LEN; i++) push_nib(p[4*i +: 4]);
  endtask

  task automatic expect_frame(input logic [4*PKT_LEN-1:0] p);
    logic [3:0] cs;
    cs = exp_seq;
    exp_q.push_back({KIND_SOF, exp_seq});
    for (int i = 0; i < PKT_LEN; i++) begin
      exp_q.push_back({KIND_DATA, p[4*i +: 4]});
      cs = cs ^ p[4*i +: 4];
    end
    exp_q.push_back({KIND_EOF, cs});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic finish_frame(input string tag);
    drain(tag);
`ifdef LINK_REPLAY_EN
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
`endif
    exp_seq    = exp_seq + 1'b1;
    exp_frames = exp_frames + 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},    {31'd0, fifo_pop},    32'd0);
    check({tag, "_valid"},  {31'd0, tx_valid},    32'd0);
    check({tag, "_kind"},   {30'd0, tx_kind},     32'd0);
    check({tag, "_dato"},   {28'd0, tx_dato},     32'd0);
    check({tag, "_busy"},   {31'd0, busy},        32'd0);
    check({tag, "_seq"},    {28'd0, seq_num},     32'd0);
    check({tag, "_frames"}, {24'd0, frames_sent}, 32'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_seq"},    {28'd0, seq_num},     {28'd0, exp_seq});
    check({tag, "_frames"}, {24'd0, frames_sent}, {24'd0, exp_frames});
  endtask

  initial begin
    int p0;
    int n;
    logic [4*PKT_LEN-1:0] p;

    reset = 1'b1; fifo_empty = 1'b1; fifo_dato = '0; tx_ready = 1'b1;
    ack_in = 1'b0; nak_in = 1'b0; exp_seq = '0; exp_frames = '0;
    #1;
    check_reset_outputs("rst");
    repeat (2) tick();

    // Test 1: preloaded 1,2,3,4; first SOF exactly PKT_LEN+2 cycles after the IDLE cycle.
    load_fifo(16'h4321);
    expect_frame(16'h4321);
    p0 = pops;
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (PKT_LEN + 1) tick();
    check("t1_no_early_sof", {30'd0, tx_kind}, 32'd0);
    tick();
    check("t1_sof_latency", {30'd0, tx_kind}, {30'd0, KIND_SOF});
    finish_frame("t1");
    check("t1_pops", pops - p0, PKT_LEN);
    check_counters("t1");

    // Test 2: two nibbles, FIFO empty for a while, then two more.
    p0 = pops;
    expect_frame(16'h4321);
    push_nib(4'h1); push_nib(4'h2);
    n = 0;
    while (pops - p0 < 2 && n < 50) begin tick(); n++; end
    check("t2_first_pops", pops - p0, 2);
    repeat (5) begin
      tick();
      check("t2_no_pop_empty", {31'd0, fifo_pop}, 32'd0);
    end
    push_nib(4'h3); push_nib(4'h4);
    finish_frame("t2");
    check("t2_pops", pops - p0, PKT_LEN);
    check_counters("t2");

    // Test 3: back-pressure on the second DATA beat.
    expect_frame(16'h4321);
    load_fifo(16'h4321);
    n = 0;
    while (!(tx_kind == KIND_DATA && tx_dato == 4'h2) && n < 100) begin tick(); n++; end
    check("t3_at_beat2", {30'd0, tx_kind}, {30'd0, KIND_DATA});
    tx_ready = 1'b0;
    repeat (3) begin
      tick();
      check("t3_hold_kind", {30'd0, tx_kind}, {30'd0, KIND_DATA});
      check("t3_hold_dato", {28'd0, tx_dato}, 32'd2);
      check("t3_hold_valid", {31'd0, tx_valid}, 32'd1);
    end
    tx_ready = 1'b1;
    finish_frame("t3");
    check_counters("t3");

    // Test 4: after reset, 17 frames; sequence wraps so frame 17 carries seq 0.
    reset = 1'b1;
    #1;
    check_reset_outputs("t4_rst");
    exp_q.delete(); exp_seq = '0; exp_frames = '0;
    tick();
    reset = 1'b0;
    for (int f = 0; f < 17; f++) begin
      p = 16'($urandom);
      if (f == 16) check("t4_seq_wrapped", {28'd0, seq_num}, 32'd0);
      expect_frame(p);
      load_fifo(p);
      finish_frame("t4");
    end
    check_counters("t4");

    // Test 5: asynchronous reset in the middle of DATA.
    expect_frame(16'h9abc);
    load_fifo(16'h9abc);
    n = 0;
    while (tx_kind != KIND_DATA && n < 100) begin tick(); n++; end
    check("t5_in_data", {30'd0, tx_kind}, {30'd0, KIND_DATA});
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("t5_async");
    exp_q.delete(); exp_seq = '0; exp_frames = '0;
    repeat (2) tick();
    reset = 1'b0;
    expect_frame(16'h8765);
    load_fifo(16'h8765);
    finish_frame("t5");
    check_counters("t5");

    // Test 6: NAK handling.
`ifdef LINK_REPLAY_EN
    p0 = pops;
    expect_frame(16'h2c5e);
    load_fifo(16'h2c5e);
    drain("t6_first");
    check("t6_wait_busy", {31'd0, busy}, 32'd1);
    check("t6_wait_valid", {31'd0, tx_valid}, 32'd0);
    check_counters("t6_wait");
    expect_frame(16'h2c5e);
    nak_in = 1'b1; ack_in = 1'b1;
    tick();
    nak_in = 1'b0; ack_in = 1'b0;
    drain("t6_replay");
    check("t6_no_replay_pops", pops - p0, PKT_LEN);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    exp_seq = exp_seq + 1'b1; exp_frames = exp_frames + 1'b1;
    check_counters("t6_ack");
    check("t6_idle", {31'd0, busy}, 32'd0);
`else
    p0 = pops;
    expect_frame(16'h2c5e);
    load_fifo(16'h2c5e);
    finish_frame("t6");
    nak_in = 1'b1;
    tick();
    nak_in = 1'b0;
    repeat (3) begin
      tick();
      check("t6_nak_busy", {31'd0, busy}, 32'd0);
      check("t6_nak_valid", {31'd0, tx_valid}, 32'd0);
    end
    check("t6_pops", pops - p0, PKT_LEN);
    check_counters("t6");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
